// File: rtl/bus_width_bridge.sv
// Narrow/wide bus bridge: packs low-bus beats into high words and
// serialises high words back into low-bus beats with a finish handshake.
module bus_width_bridge #(
    parameter int LOW_WIDTH  = 8,
    parameter int RATIO_LOG  = 2,
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int TIMEOUT    = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [LOW_WIDTH-1:0]                 low_read_data,
    input  logic                                 low_read_valid,
    output logic [LOW_WIDTH*(2**RATIO_LOG)-1:0]  high_read_data,
    output logic                                 high_read_valid,
    output logic                                 pack_timeout,
    input  logic [LOW_WIDTH*(2**RATIO_LOG)-1:0]  high_write_data,
    input  logic                                 high_write_valid,
    output logic                                 high_write_ready,
    output logic                                 unpack_overflow,
    output logic [LOW_WIDTH-1:0]                 low_write_data,
    output logic                                 low_write_valid,
    input  logic                                 low_write_finish
);
    localparam int RATIO = 2 ** RATIO_LOG;
    localparam int HW    = LOW_WIDTH * RATIO;
    localparam int IW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

    logic [RATIO_LOG-1:0] cnt_q, cnt_d, lane;
    logic [HW-1:0]        acc_q, acc_d, hrd_q, hrd_d;
    logic                 hrv_q, hrv_d, pto_q, pto_d;
    logic [IW-1:0]        idle_q, idle_d;

    state_e               state_q, state_d;
    logic [HW-1:0]        word_q, word_d;
    logic [RATIO_LOG-1:0] idx_q, idx_d;
    logic [LOW_WIDTH-1:0] lwd_q, lwd_d;
    logic                 ready_q, ready_d, ovf_q, ovf_d;

    // Lane order reverses for big-endian: RATIO-1-i == ~i for power-of-two RATIO.
    function automatic logic [LOW_WIDTH-1:0] lane_of(
        input logic [HW-1:0]        w,
        input logic [RATIO_LOG-1:0] i
    );
        logic [RATIO_LOG-1:0] l;
        l = BIG_ENDIAN ? ~i : i;
        return w[l*LOW_WIDTH +: LOW_WIDTH];
    endfunction

    assign lane = BIG_ENDIAN ? ~cnt_q : cnt_q;

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        hrd_d  = hrd_q;
        hrv_d  = 1'b0;
        pto_d  = 1'b0;
        idle_d = idle_q;
        if (low_read_valid) begin
            acc_d[lane*LOW_WIDTH +: LOW_WIDTH] = low_read_data;
            cnt_d  = cnt_q + RATIO_LOG'(1);
            idle_d = '0;
            if (cnt_q == '1) begin
                hrv_d = 1'b1;
                hrd_d = acc_d;
            end
        end else if (cnt_q == '0) begin
            idle_d = '0;
        end else if (TIMEOUT > 0) begin
            if (idle_q == IW'(TIMEOUT - 1)) begin
                cnt_d  = '0;
                idle_d = '0;
                pto_d  = 1'b1;
            end else begin
                idle_d = idle_q + IW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        lwd_d   = lwd_q;
        ovf_d   = high_write_valid && (state_q != IDLE);
        unique case (state_q)
            IDLE: if (high_write_valid) begin
                word_d  = high_write_data;
                idx_d   = '0;
                lwd_d   = lane_of(high_write_data, '0);
                state_d = SEND;
            end
            SEND: state_d = WAIT;
            WAIT: if (low_write_finish) begin
                if (idx_q == '1) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + RATIO_LOG'(1);
                    lwd_d   = lane_of(word_q, idx_d);
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            hrd_q   <= '0;
            hrv_q   <= 1'b0;
            pto_q   <= 1'b0;
            idle_q  <= '0;
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            lwd_q   <= '0;
            ready_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            hrd_q   <= hrd_d;
            hrv_q   <= hrv_d;
            pto_q   <= pto_d;
            idle_q  <= idle_d;
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            lwd_q   <= lwd_d;
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
        end
    end

    assign high_read_data   = hrd_q;
    assign high_read_valid  = hrv_q;
    assign pack_timeout     = pto_q;
    assign high_write_ready = ready_q;
    assign unpack_overflow  = ovf_q;
    assign low_write_data   = lwd_q;
    assign low_write_valid  = (state_q == SEND);
endmodule
